// File: rtl/router_pkt_source.sv
// Packet source for the router input port: buffers host payload bytes, then sends
// header {len,addr}, the payload and an XOR parity byte while honouring router busy.
module router_pkt_source #(
  parameter int LEN_W  = 6,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [LEN_W:0]    buf_count,
  output logic              buf_full,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              corrupt_parity,
  output logic              ready,
  output logic              start_err,
  input  logic              busy,
  output logic              packet_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              done
);

  localparam logic [LEN_W:0] FULL_CNT = {1'b0, {LEN_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [0:(2**LEN_W)-1];
  logic [LEN_W-1:0]  wr_ptr, wr_ptr_next;
  logic [LEN_W-1:0]  rd_ptr, rd_ptr_next;
  logic [LEN_W-1:0]  remain, remain_next;
  logic [LEN_W:0]    count_next;
  logic [DATA_W-1:0] acc, acc_next;
  logic [DATA_W-1:0] data_next;
  logic              corrupt, corrupt_next;
  logic              pv_next, ready_next, done_next, err_next, full_next;
  logic              push, pop;
  logic [DATA_W-1:0] head_byte;

  assign head_byte = mem[rd_ptr];

  always_comb begin
    state_next   = state;
    wr_ptr_next  = wr_ptr;
    rd_ptr_next  = rd_ptr;
    remain_next  = remain;
    acc_next     = acc;
    data_next    = data_out;
    corrupt_next = corrupt;
    pv_next      = packet_valid;
    ready_next   = ready;
    done_next    = 1'b0;
    err_next     = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        // start takes priority over a simultaneous write, even when rejected
        if (start) begin
          if (buf_count != '0 && dest_addr != '1) begin
            state_next   = HEADER;
            data_next    = {buf_count[LEN_W-1:0], dest_addr};
            acc_next     = {buf_count[LEN_W-1:0], dest_addr};
            remain_next  = buf_count[LEN_W-1:0];
            corrupt_next = corrupt_parity;
            pv_next      = 1'b1;
            ready_next   = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end else if (wr_en && buf_count != FULL_CNT) begin
          push = 1'b1;
        end
      end
      HEADER: begin
        if (!busy) begin
          pop         = 1'b1;
          data_next   = head_byte;
          acc_next    = acc ^ head_byte;
          remain_next = remain - 1'b1;
          state_next  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          if (remain == '0) begin
            state_next = PARITY;
            pv_next    = 1'b0;
            data_next  = corrupt ? ~acc : acc;
          end else begin
            pop         = 1'b1;
            data_next   = head_byte;
            acc_next    = acc ^ head_byte;
            remain_next = remain - 1'b1;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          state_next = IDLE;
          done_next  = 1'b1;
          data_next  = '0;
          ready_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (push) wr_ptr_next = wr_ptr + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr + 1'b1;

    count_next = buf_count;
    if (push)     count_next = buf_count + 1'b1;
    else if (pop) count_next = buf_count - 1'b1;
    full_next = (count_next == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      remain       <= '0;
      buf_count    <= '0;
      buf_full     <= 1'b0;
      acc          <= '0;
      corrupt      <= 1'b0;
      data_out     <= '0;
      packet_valid <= 1'b0;
      ready        <= 1'b1;
      done         <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      state        <= state_next;
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      remain       <= remain_next;
      buf_count    <= count_next;
      buf_full     <= full_next;
      acc          <= acc_next;
      corrupt      <= corrupt_next;
      data_out     <= data_next;
      packet_valid <= pv_next;
      ready        <= ready_next;
      done         <= done_next;
      start_err    <= err_next;
    end
  end

endmodule
